// File: rtl/burst_timer.sv
// rtl/burst_timer.sv - sequences a counter through a fixed number of periods per trigger
module burst_timer #(
    parameter int repetitions = 4,
    parameter int gap_cycles  = 0,
    parameter int rep_width   = $clog2(repetitions + 1),
    parameter int gap_width   = (gap_cycles > 0) ? $clog2(gap_cycles + 1) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic                 abort,
    input  logic                 counter_overflow,
    output logic                 counter_reset,
    output logic                 counter_start,
    output logic                 counter_stop,
    output logic                 active,
    output logic [rep_width-1:0] repetition,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    // Count value that the final period's overflow completes from, and the
    // count reported once the burst has finished.
    localparam logic [rep_width-1:0] REP_LAST = rep_width'(repetitions - 1);
    localparam logic [rep_width-1:0] REP_FULL = rep_width'(repetitions);
    // The gap counter counts down to zero inclusive, so G gap cycles load G-1.
    localparam logic [gap_width-1:0] GAP_LOAD =
        (gap_cycles > 0) ? gap_width'(gap_cycles - 1) : '0;

    state_t               state_q, state_d;
    logic [rep_width-1:0] rep_q, rep_d;
    logic [gap_width-1:0] gap_q, gap_d;
    logic                 ovf_q;
    logic                 stop_q, stop_d;
    logic                 ovf_edge;

    assign ovf_edge = counter_overflow & ~ovf_q;

    // State, progress count, gap timer, overflow history and stop pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rep_q   <= '0;
            gap_q   <= '0;
            ovf_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            ovf_q   <= counter_overflow;
            stop_q  <= stop_d;
        end
    end

    // Next-state logic: abort beats overflow/gap expiry, which beat trigger.
    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        stop_d  = 1'b0;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            stop_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        rep_d   = '0;
                        state_d = S_ARM;
                    end
                end
                S_ARM: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (ovf_edge) begin
                        if (rep_q == REP_LAST) begin
                            rep_d   = REP_FULL;
                            state_d = S_DONE;
                        end else begin
                            rep_d = rep_q + rep_width'(1);
                            if (gap_cycles == 0) begin
                                state_d = S_ARM;
                            end else begin
                                gap_d   = GAP_LOAD;
                                state_d = S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_d = S_ARM;
                    end else begin
                        gap_d = gap_q - gap_width'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign counter_reset = (state_q == S_ARM);
    assign counter_start = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign active        = (state_q != S_IDLE);
    assign counter_stop  = stop_q;
    assign repetition    = rep_q;

endmodule
